// File: rtl/mandelbrot_pkg.sv
// Shared types and default constants for the Mandelbrot pipeline:
// Q4.12 coordinate type, viewport record and default 640x480 timing.
package mandelbrot_pkg;

  localparam int FRAC_BITS = 12;
  localparam int Q_ONE     = 1 << FRAC_BITS;
  localparam int COORD_W   = 16;
  localparam int CNT_W     = 8;

  typedef logic signed [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t x0;
    coord_t y0;
    coord_t step;
  } viewport_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_X0_RST   = -10240;  // -2.5
  localparam int DEF_Y0_RST   = 5120;    // +1.25
  localparam int DEF_STEP_RST = 22;

  // Truncate an integer to a Q4.12 coordinate (two's complement wrap).
  function automatic coord_t to_coord(int v);
    return COORD_W'(v);
  endfunction

  // step * k, truncated to the coordinate width.
  function automatic coord_t q_scale(coord_t step, int k);
    return COORD_W'(int'(step) * k);
  endfunction

endpackage

// File: rtl/mandelbrot_sync_cnt.sv
// Raster h/v counters with de/hs/vs decode plus line-end and frame-wrap
// strobes, all decoded from the current counter state.
module mandelbrot_sync_cnt #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic de_o,
  output logic hs_o,
  output logic vs_o,
  output logic vact_o,
  output logic line_end_o,
  output logic frame_end_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          h_last, v_last;

  // Wrap detection and status decode from the current counter state.
  always_comb begin
    h_last      = (h_q == HW'(H_TOTAL - 1));
    v_last      = (v_q == VW'(V_TOTAL - 1));
    line_end_o  = h_last;
    frame_end_o = h_last && v_last;
    vact_o      = int'(v_q) < V_ACTIVE;
    de_o        = (int'(h_q) < H_ACTIVE) && vact_o;
    hs_o        = (int'(h_q) >= H_ACTIVE + H_FP) &&
                  (int'(h_q) <  H_ACTIVE + H_FP + H_SYNC);
    vs_o        = (int'(v_q) >= V_ACTIVE + V_FP) &&
                  (int'(v_q) <  V_ACTIVE + V_FP + V_SYNC);
  end

  // Counter next state: h every clock, v when h wraps.
  always_comb begin
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (h_last) begin
      h_d = '0;
      v_d = v_last ? '0 : v_q + 1'b1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

endmodule

// File: rtl/mandelbrot_scan_gen.sv
// Source end of the Mandelbrot chain: raster timing plus per-pixel (cx, cy)
// with a zero initial orbit. Viewport loads are shadowed and applied only at
// the frame wrap. Define MANDEL_SCAN_CENTER_EN to treat i_vp_x0/i_vp_y0 as
// the viewport centre instead of the top-left corner.
module mandelbrot_scan_gen
  import mandelbrot_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int X0_RST   = DEF_X0_RST,
  parameter int Y0_RST   = DEF_Y0_RST,
  parameter int STEP_RST = DEF_STEP_RST
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_vp_x0,
  input  logic [15:0] i_vp_y0,
  input  logic [15:0] i_vp_step,
  input  logic        i_vp_ld,
  output logic        o_de,
  output logic        o_vs,
  output logic        o_hs,
  output logic [15:0] o_x,
  output logic [15:0] o_y,
  output logic [15:0] o_cx,
  output logic [15:0] o_cy,
  output logic [7:0]  o_cnt
);

  localparam viewport_t VP_RST = '{
    x0:   to_coord(X0_RST),
    y0:   to_coord(Y0_RST),
    step: to_coord(STEP_RST)
  };

  logic de, hs, vs, vact, line_end, frame_end;

  viewport_t ld_vp;
  viewport_t act_q, act_d;
  viewport_t pend_q, pend_d;
  logic      pend_vld_q, pend_vld_d;
  coord_t    cx_acc_q, cx_acc_d;
  coord_t    cy_acc_q, cy_acc_d;
  logic      de_q, hs_q, vs_q;
  coord_t    cx_q, cx_d, cy_q, cy_d;

  mandelbrot_sync_cnt #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_sync (
    .clk_i       (i_clk),
    .rst_i       (i_rst),
    .de_o        (de),
    .hs_o        (hs),
    .vs_o        (vs),
    .vact_o      (vact),
    .line_end_o  (line_end),
    .frame_end_o (frame_end)
  );

  // Viewport as captured from the load inputs (corner form).
  always_comb begin
    ld_vp.step = coord_t'(i_vp_step);
`ifdef MANDEL_SCAN_CENTER_EN
    ld_vp.x0   = coord_t'(i_vp_x0) - q_scale(coord_t'(i_vp_step), H_ACTIVE / 2);
    ld_vp.y0   = coord_t'(i_vp_y0) + q_scale(coord_t'(i_vp_step), V_ACTIVE / 2);
`else
    ld_vp.x0   = coord_t'(i_vp_x0);
    ld_vp.y0   = coord_t'(i_vp_y0);
`endif
  end

  // Shadow viewport: pending capture mid-frame, promotion or bypass at wrap.
  always_comb begin
    act_d      = act_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (frame_end) begin
      if (i_vp_ld) begin
        act_d = ld_vp;
      end else if (pend_vld_q) begin
        act_d = pend_q;
      end
      pend_vld_d = 1'b0;
    end else if (i_vp_ld) begin
      pend_d     = ld_vp;
      pend_vld_d = 1'b1;
    end
  end

  // Coordinate accumulators; reloads use act_d so a new viewport lands on
  // the first pixel of the next frame.
  always_comb begin
    cx_acc_d = cx_acc_q;
    cy_acc_d = cy_acc_q;
    if (line_end) begin
      cx_acc_d = act_d.x0;
    end else if (de) begin
      cx_acc_d = cx_acc_q + act_q.step;
    end
    if (frame_end) begin
      cy_acc_d = act_d.y0;
    end else if (line_end && vact) begin
      cy_acc_d = cy_acc_q - act_q.step;
    end
  end

  // Output data: constants only on active pixels, zero during blanking.
  always_comb begin
    cx_d = de ? cx_acc_q : '0;
    cy_d = de ? cy_acc_q : '0;
  end

  // Viewport and accumulator state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      act_q      <= VP_RST;
      pend_q     <= VP_RST;
      pend_vld_q <= 1'b0;
      cx_acc_q   <= VP_RST.x0;
      cy_acc_q   <= VP_RST.y0;
    end else begin
      act_q      <= act_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      cx_acc_q   <= cx_acc_d;
      cy_acc_q   <= cy_acc_d;
    end
  end

  // Registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      de_q <= 1'b0;
      hs_q <= 1'b0;
      vs_q <= 1'b0;
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      de_q <= de;
      hs_q <= hs;
      vs_q <= vs;
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

  assign o_de  = de_q;
  assign o_hs  = hs_q;
  assign o_vs  = vs_q;
  assign o_cx  = cx_q;
  assign o_cy  = cy_q;
  assign o_x   = '0;
  assign o_y   = '0;
  assign o_cnt = '0;

endmodule

// File: tb/tb_mandelbrot_scan_gen.sv
// Directed bench for mandelbrot_scan_gen on a 7x6 raster (4x3 active).
module tb_mandelbrot_scan_gen;

  localparam int HT = 7;
  localparam int VT = 6;
  localparam int FR = HT * VT;

  localparam int RX0 = -10240;
  localparam int RY0 = 5120;
  localparam int RST_STEP = 16;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [15:0] i_vp_x0, i_vp_y0, i_vp_step;
  logic        i_vp_ld;
  logic        o_de, o_vs, o_hs;
  logic [15:0] o_x, o_y, o_cx, o_cy;
  logic [7:0]  o_cnt;

  int total = 0;
  int bad   = 0;

  logic [15:0] cap_cx [0:FR-1];
  logic [15:0] cap_cy [0:FR-1];
  logic        cap_hs [0:FR-1];

  mandelbrot_scan_gen #(
    .H_ACTIVE (4), .H_FP (1), .H_SYNC (1), .H_BP (1),
    .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .X0_RST   (RX0), .Y0_RST (RY0), .STEP_RST (RST_STEP)
  ) dut (
    .i_clk     (clk),
    .i_rst     (i_rst),
    .i_vp_x0   (i_vp_x0),
    .i_vp_y0   (i_vp_y0),
    .i_vp_step (i_vp_step),
    .i_vp_ld   (i_vp_ld),
    .o_de      (o_de),
    .o_vs      (o_vs),
    .o_hs      (o_hs),
    .o_x       (o_x),
    .o_y       (o_y),
    .o_cx      (o_cx),
    .o_cy      (o_cy),
    .o_cnt     (o_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, " de"}, 32'(o_de), 32'd0);
    check_val({tag, " hs"}, 32'(o_hs), 32'd0);
    check_val({tag, " vs"}, 32'(o_vs), 32'd0);
    check_val({tag, " cx"}, 32'(o_cx), 32'd0);
    check_val({tag, " cy"}, 32'(o_cy), 32'd0);
  endtask

  // Runs ncyc output cycles from pixel (0,0), checking every output against
  // the expected viewport; up to two load strobes at cycle ldc0 / ldc1.
  task automatic run_frame(input string nm, input int ncyc,
                           input int ex0, input int ey0, input int estep,
                           input int ldc0, input int lx0, input int ly0, input int ls0,
                           input int ldc1, input int lx1, input int ly1, input int ls1);
    int de_n = 0;
    int vs_n = 0;
    for (int c = 0; c < ncyc; c++) begin
      int h;
      int v;
      logic ede, ehs, evs;
      logic [15:0] ecx, ecy;
      h = c % HT;
      v = c / HT;
      i_vp_ld = 1'b0;
      if (c == ldc0) begin
        i_vp_x0 = 16'(lx0); i_vp_y0 = 16'(ly0); i_vp_step = 16'(ls0); i_vp_ld = 1'b1;
      end else if (c == ldc1) begin
        i_vp_x0 = 16'(lx1); i_vp_y0 = 16'(ly1); i_vp_step = 16'(ls1); i_vp_ld = 1'b1;
      end
      @(posedge clk);
      #1;
      i_vp_ld = 1'b0;
      ede = (h < 4) && (v < 3);
      ehs = (h == 5);
      evs = (v == 4);
      ecx = ede ? 16'(ex0 + h * estep) : 16'h0;
      ecy = ede ? 16'(ey0 - v * estep) : 16'h0;
      check_val($sformatf("%s c%0d de", nm, c), 32'(o_de), 32'(ede));
      check_val($sformatf("%s c%0d hs", nm, c), 32'(o_hs), 32'(ehs));
      check_val($sformatf("%s c%0d vs", nm, c), 32'(o_vs), 32'(evs));
      check_val($sformatf("%s c%0d cx", nm, c), 32'(o_cx), 32'(ecx));
      check_val($sformatf("%s c%0d cy", nm, c), 32'(o_cy), 32'(ecy));
      check_val($sformatf("%s c%0d orbit", nm, c), {o_x, o_y} | 32'(o_cnt), 32'd0);
      cap_cx[c] = o_cx;
      cap_cy[c] = o_cy;
      cap_hs[c] = o_hs;
      if (o_de) de_n++;
      if (o_vs) vs_n++;
    end
    if (ncyc == FR) begin
      check_val({nm, " de_count"}, 32'(de_n), 32'd12);
      check_val({nm, " vs_count"}, 32'(vs_n), 32'd7);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] e16;
    int line0_cx [7];
    line0_cx = '{RX0, RX0 + 16, RX0 + 32, RX0 + 48, 0, 0, 0};

    i_rst     = 1'b1;
    i_vp_x0   = '0;
    i_vp_y0   = '0;
    i_vp_step = '0;
    i_vp_ld   = 1'b0;

    #20;
    check_idle("reset");
    #2;
    i_rst = 1'b0;

    // Frame A: reset viewport; mid-frame load of (0,0,1) must not disturb it.
    run_frame("A", FR, RX0, RY0, RST_STEP, 10, 0, 0, 1, -1, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      e16 = 16'(line0_cx[i]);
      check_val($sformatf("A line0 cx%0d", i), 32'(cap_cx[i]), 32'(e16));
      check_val($sformatf("A line0 hs%0d", i), 32'(cap_hs[i]), 32'(i == 5));
    end
    e16 = 16'(RY0 - 32);
    check_val("A line2 cy", 32'(cap_cy[14]), 32'(e16));

    // Frame B: pending (0,0,1) now active; load on the wrap cycle bypasses.
    run_frame("B", FR, 0, 0, 1, FR - 1, 100, 200, 2, -1, 0, 0, 0);
    check_val("B pix32 cx", 32'(cap_cx[17]), 32'h0003);
    check_val("B pix32 cy", 32'(cap_cy[17]), 32'hFFFE);

    // Frame C: wrap-cycle load active; two loads, last one wins.
    run_frame("C", FR, 100, 200, 2, 5, 1000, 2000, 5, 20, -50, 60, 3);

    // Frame D: second load active; pending load then reset mid-line.
    run_frame("D", 18, -50, 60, 3, 10, 7, 7, 7, -1, 0, 0, 0);
    #2;
    i_rst = 1'b1;
    #1;
    check_idle("midreset");
    @(posedge clk);
    #3;
    i_rst = 1'b0;

    // Frames E/F: reset viewport, discarded pending load never appears.
    run_frame("E", FR, RX0, RY0, RST_STEP, -1, 0, 0, 0, -1, 0, 0, 0);
    run_frame("F", FR, RX0, RY0, RST_STEP, -1, 0, 0, 0, -1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mandelbrot_scan_gen.md
# mandelbrot_scan_gen

Source end of the Mandelbrot iteration chain:
- Generates raster video timing (de/vs/hs) and, for every active pixel, the complex-plane constant (cx, cy) plus a zero initial orbit (x = y = 0, cnt = 0).
- Output feeds the first cascaded iteration stage directly.
- The viewport (top-left corner and pixel step, Q4.12) is loaded through a shadow register and takes effect only at frame boundaries, so a zoom/pan never tears a frame.

## Interface
Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch (clocks)
- V_ACTIVE, 480, active lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porches/sync (lines)
- X0_RST, -10240 (-2.5), reset viewport left edge, Q4.12
- Y0_RST, 5120 (+1.25), reset viewport top edge, Q4.12
- STEP_RST, 22, reset pixel step, Q4.12

Ports (one clock; reset is asynchronous and active-high):
- i_clk  in  1  pixel clock
- i_rst  in  1  asynchronous active-high reset
- i_vp_x0  in  16  new left edge, signed Q4.12
- i_vp_y0  in  16  new top edge, signed Q4.12
- i_vp_step  in  16  new step, signed Q4.12
- i_vp_ld  in  1  single-cycle load strobe for the three values above
- o_de / o_vs / o_hs  out  1 each  data enable, vertical sync, horizontal sync (sync asserted high)
- o_x / o_y  out  16  initial orbit, signed Q4.12
- o_cx / o_cy  out  16  pixel constant, signed Q4.12
- o_cnt  out  8  initial iteration count

## Operation
- Counters:
  - h: 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - v: 0..V_TOTAL-1; v advances when h wraps. Both wrap to 0 after (H_TOTAL-1, V_TOTAL-1) (the frame wrap).
- Decode:
  - de = h<H_ACTIVE && v<V_ACTIVE.
  - hs = H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vs = V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, for the whole line.
- Constant generation: pixel (h,v) active → cx = x0 + h·step, cy = y0 - v·step (y increases upward). Implemented by accumulators, no multipliers:
  - cx loads x0 at h=0 and adds step per active pixel.
  - cy loads y0 at the frame wrap and subtracts step once per active line.
  - All arithmetic is 16-bit two's complement and wraps silently.
- Outputs during blanking (de=0): o_cx, o_cy, o_x, o_y, o_cnt = 0.
- Outputs during active pixels: o_x = o_y = 0, o_cnt = 0.
- Viewport shadow:
  - i_vp_ld=1 captures the three inputs into the pending regs and sets the pending flag; a later ld overwrites them (last wins).
  - At the frame wrap with the flag set, active viewport ← pending and the flag clears.
  - ld asserted on the frame-wrap cycle itself: the new inputs bypass straight to active for the next frame; the flag stays clear.
  - Mid-frame ld never changes cx/cy of the current frame.

## Timing
- All outputs registered. Outputs in cycle t+1 describe counter state (h,v) of cycle t.
- Reset, asynchronous: h=v=0, accumulators and active viewport = *_RST, pending flag = 0, all outputs 0.
- First rising edge after i_rst deasserts: counters advance. Outputs on that edge show pixel (0,0): o_de=1, o_cx=X0_RST, o_cy=Y0_RST.
- Reset asserted mid-frame: immediate return to the reset state; pending load discarded.
- Throughput: one pixel per clock; no back-pressure.

## Configuration
- MANDEL_SCAN_CENTER_EN defined:
  - i_vp_x0/i_vp_y0 are the viewport centre.
  - Corner computed when captured into pending: x0 = xc - step·(H_ACTIVE/2), y0 = yc + step·(V_ACTIVE/2), truncated to 16 bits.
  - *_RST still denote the corner.
- Undefined: inputs are the top-left corner, as described above.

## Structure
- Shared package mandelbrot_pkg:
  - FRAC_BITS=12, Q_ONE=4096, the Q4.12 coordinate type.
  - Default timing constants, also used by the iteration stages and the colour mapper.
- One sub-module: mandelbrot_sync_cnt (h/v counters + de/hs/vs/frame-wrap decode). The viewport shadow and accumulators stay in the top.

## Test plan
All scenarios use H_ACTIVE=4, H_FP=1, H_SYNC=1, H_BP=1, V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1, i.e. H_TOTAL=7, V_TOTAL=6.
- Reset release, STEP_RST=16 → line 0 o_cx = X0_RST, +16, +32, +48 with o_de=1, then 3 blank cycles with o_cx=0; o_hs high only on the 6th output cycle.
- Frame count → o_vs high for exactly 7 cycles per 42-cycle frame, during line 4; o_de high 12 cycles per frame.
- Line 2, pixel 0 → o_cy = Y0_RST - 32; o_x=o_y=o_cnt=0 throughout.
- i_vp_ld mid-frame with x0=0, y0=0, step=1 → current frame unchanged; next frame pixel (3,2) gives o_cx=3, o_cy=-2.
- i_vp_ld on the frame-wrap cycle → applied to the very next frame. Two lds in one frame → only the second takes effect.
- i_rst pulsed mid-line with a pending load → outputs 0 immediately; after release the reset viewport is used and the pending load is lost.
